controller_disp_seq: RTL and testbench

CONTROLLER_DISP_SEQ -- requirements
Module: controller_disp_seq

---
 rtl/controller_disp_seq.sv | 191 +++++++++++++++++++
 tb/tb_controller_disp_seq.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/controller_disp_seq.sv
// Display power sequencer with an Avalon-MM register file: powers the panel up/down
// through timed states and optionally blinks the display enable while on.
module controller_disp_seq (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [1:0]  address,
    input  logic        chipselect,
    input  logic        write_n,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    output logic        disp_pwr,
    output logic        disp_en,
    output logic        irq
);

    typedef enum logic [2:0] {
        StOff      = 3'd0,
        StPwrUp    = 3'd1,
        StOn       = 3'd2,
        StBlinkOff = 3'd3,
        StPwrDn    = 3'd4
    } state_e;

    localparam logic [1:0] AddrCtrl   = 2'd0;
    localparam logic [1:0] AddrDelay  = 2'd1;
    localparam logic [1:0] AddrBlink  = 2'd2;
    localparam logic [1:0] AddrStatus = 2'd3;

    localparam int unsigned CtrlEn    = 0;
    localparam int unsigned CtrlBlink = 1;
    localparam int unsigned CtrlIe    = 2;

    state_e      r_state;
    state_e      w_state_d;
    logic [15:0] r_cnt;
    logic [15:0] w_cnt_d;
    logic [15:0] w_cnt_dec;
    logic [2:0]  r_ctrl;
    logic [15:0] r_delay;
    logic [15:0] r_blink;
    logic        r_pend;
    logic        r_pwr;
    logic        r_en;

    logic        w_wr;
    logic        w_wr_ctrl;
    logic        w_wr_delay;
    logic        w_wr_blink;
    logic        w_wr_status;
    logic        w_pend_set;
    logic        w_blink_act;
    logic        w_pwr_d;
    logic        w_en_d;
    logic [15:0] w_unused_wdata;

    assign w_wr        = chipselect & ~write_n;
    assign w_wr_ctrl   = w_wr & (address == AddrCtrl);
    assign w_wr_delay  = w_wr & (address == AddrDelay);
    assign w_wr_blink  = w_wr & (address == AddrBlink);
    assign w_wr_status = w_wr & (address == AddrStatus);

    assign w_unused_wdata = writedata[31:16];

    // Register file
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_ctrl  <= 3'd0;
            r_delay <= 16'd0;
            r_blink <= 16'd0;
            r_pend  <= 1'b0;
        end else begin
            if (w_wr_ctrl) begin
                r_ctrl <= writedata[2:0];
            end
            if (w_wr_delay) begin
                r_delay <= writedata[15:0];
            end
            if (w_wr_blink) begin
                r_blink <= writedata[15:0];
            end
            // A completion event in the same cycle as a software clear keeps pend set.
            if (w_pend_set) begin
                r_pend <= 1'b1;
            end else if (w_wr_status && writedata[3]) begin
                r_pend <= 1'b0;
            end
        end
    end

    // Sequencer state, shared counter and registered panel outputs
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= StOff;
            r_cnt   <= 16'd0;
            r_pwr   <= 1'b0;
            r_en    <= 1'b0;
        end else begin
            r_state <= w_state_d;
            r_cnt   <= w_cnt_d;
            r_pwr   <= w_pwr_d;
            r_en    <= w_en_d;
        end
    end

    assign w_cnt_dec   = r_cnt - 16'd1;
    assign w_blink_act = r_ctrl[CtrlBlink] & (r_blink != 16'd0);

    always_comb begin
        w_state_d  = r_state;
        w_cnt_d    = r_cnt;
        w_pend_set = 1'b0;
        case (r_state)
            StOff: begin
                if (r_ctrl[CtrlEn]) begin
                    w_state_d = StPwrUp;
                    w_cnt_d   = r_delay;
                end
            end
            StPwrUp: begin
                if (!r_ctrl[CtrlEn]) begin
                    w_state_d = StPwrDn;
                    w_cnt_d   = r_delay;
                end else if (r_cnt == 16'd0) begin
                    w_state_d  = StOn;
                    w_cnt_d    = r_blink;
                    w_pend_set = 1'b1;
                end else begin
                    w_cnt_d = w_cnt_dec;
                end
            end
            StOn: begin
                // With blink inactive the counter simply holds its value.
                if (!r_ctrl[CtrlEn]) begin
                    w_state_d = StPwrDn;
                    w_cnt_d   = r_delay;
                end else if (w_blink_act) begin
                    if (r_cnt == 16'd0) begin
                        w_state_d = StBlinkOff;
                        w_cnt_d   = r_blink;
                    end else begin
                        w_cnt_d = w_cnt_dec;
                    end
                end
            end
            StBlinkOff: begin
                if (!r_ctrl[CtrlEn]) begin
                    w_state_d = StPwrDn;
                    w_cnt_d   = r_delay;
                end else if (!w_blink_act || (r_cnt == 16'd0)) begin
                    w_state_d = StOn;
                    w_cnt_d   = r_blink;
                end else begin
                    w_cnt_d = w_cnt_dec;
                end
            end
            StPwrDn: begin
                // Power-down always runs to completion, even if en is re-asserted.
                if (r_cnt == 16'd0) begin
                    w_state_d  = StOff;
                    w_pend_set = 1'b1;
                end else begin
                    w_cnt_d = w_cnt_dec;
                end
            end
            default: begin
                w_state_d = StOff;
                w_cnt_d   = 16'd0;
            end
        endcase
    end

    // Outputs follow the state they are registered alongside.
    assign w_pwr_d = (w_state_d != StOff);
    assign w_en_d  = (w_state_d == StOn);

    always_comb begin
        readdata = 32'd0;
        case (address)
            AddrCtrl:   readdata = {29'd0, r_ctrl};
            AddrDelay:  readdata = {16'd0, r_delay};
            AddrBlink:  readdata = {16'd0, r_blink};
            AddrStatus: readdata = {28'd0, r_pend, r_state};
            default:    readdata = 32'd0;
        endcase
    end

    assign disp_pwr = r_pwr;
    assign disp_en  = r_en;
    assign irq      = r_pend & r_ctrl[CtrlIe];

endmodule

// File: tb/tb_controller_disp_seq.sv
// Directed bench for controller_disp_seq: expectations are queued as stimulus is
// applied and popped when the corresponding DUT output is sampled.
module tb_controller_disp_seq;

    logic        clk;
    logic        reset_n;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic        disp_pwr;
    logic        disp_en;
    logic        irq;

    typedef struct {
        string       tag;
        logic [31:0] val;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    controller_disp_seq dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .disp_pwr   (disp_pwr),
        .disp_en    (disp_en),
        .irq        (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic sb_push(input string tag, input logic [31:0] val);
        exp_t e;
        e.tag = tag;
        e.val = val;
        sb.push_back(e);
    endtask

    task automatic sb_check(input logic [31:0] obs);
        exp_t e;
        n_tests++;
        if (sb.size() == 0) begin
            n_fail++;
            $error("FAIL sb_empty observed=%0h expected=<none>", obs);
        end else begin
            e = sb.pop_front();
            assert (obs === e.val) else begin
                n_fail++;
                $error("FAIL %s observed=%0h expected=%0h", e.tag, obs, e.val);
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_reg(input logic [1:0] a, input logic [31:0] d);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        tick();
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = 32'd0;
        address    = 2'd3;
        #1;
    endtask

    task automatic read_reg(input logic [1:0] a, output logic [31:0] d);
        address = a;
        #1;
        d = readdata;
        address = 2'd3;
    endtask

    task automatic read_state(output logic [31:0] st);
        logic [31:0] d;
        read_reg(2'd3, d);
        st = {29'd0, d[2:0]};
    endtask

    initial begin
        logic [31:0] d;
        int          n;
        int          zeros;

        reset_n    = 1'b0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        address    = 2'd3;
        writedata  = 32'd0;
        repeat (2) @(posedge clk);
        #1;

        // Reset values
        for (int a = 0; a < 4; a++) begin
            sb_push($sformatf("rst_reg%0d", a), 32'd0);
            read_reg(a[1:0], d);
            sb_check(d);
        end
        sb_push("rst_outs", 32'd0);
        sb_check({29'd0, disp_pwr, disp_en, irq});
        reset_n = 1'b1;
        tick();

        // Power-up with DELAY=5
        write_reg(2'd1, 32'd5);
        sb_push("pwr_before_edge", 32'd0);
        write_reg(2'd0, 32'd1);
        sb_check({31'd0, disp_pwr});
        sb_push("pwr_rise", 32'd1);
        sb_push("en_in_pwrup", 32'd0);
        tick();
        sb_check({31'd0, disp_pwr});
        sb_check({31'd0, disp_en});
        sb_push("en_rise_delay", 32'd6);
        n = 0;
        while (!disp_en && n < 20) begin
            tick();
            n++;
        end
        sb_check(n);
        sb_push("status_on_pend", 32'hA);
        read_reg(2'd3, d);
        sb_check(d);
        sb_push("irq_ie_off", 32'd0);
        sb_check({31'd0, irq});

        // Interrupt enable and pend clear
        sb_push("irq_set", 32'd1);
        write_reg(2'd0, 32'h5);
        sb_check({31'd0, irq});
        sb_push("irq_clr", 32'd0);
        sb_push("status_after_clr", 32'h2);
        write_reg(2'd3, 32'h8);
        sb_check({31'd0, irq});
        read_reg(2'd3, d);
        sb_check(d);

        // Blink 4 cycles high / 4 cycles low
        write_reg(2'd2, 32'd3);
        write_reg(2'd0, 32'h3);
        n = 0;
        while (disp_en && n < 10) begin
            tick();
            n++;
        end
        sb_push("blink_off_state", 32'd3);
        read_state(d);
        sb_check(d);
        sb_push("blink_low1", 32'd4);
        sb_push("blink_high", 32'd4);
        sb_push("blink_low2", 32'd4);
        for (int ph = 0; ph < 3; ph++) begin
            n = 0;
            while ((disp_en == (ph == 1)) && n < 20) begin
                n++;
                tick();
            end
            sb_check(n);
        end

        // BLINK=0 stops blinking with the display left on
        write_reg(2'd2, 32'd0);
        repeat (2) tick();
        sb_push("no_blink_en_low", 32'd0);
        zeros = 0;
        repeat (12) begin
            if (!disp_en) zeros++;
            tick();
        end
        sb_check(zeros);

        // Power down to OFF, then abort a power-up two cycles in
        write_reg(2'd0, 32'd0);
        n = 0;
        while (disp_pwr && n < 30) begin
            tick();
            n++;
        end
        sb_push("off_pwr", 32'd0);
        sb_check({31'd0, disp_pwr});
        sb_push("status_cleared", 32'd0);
        write_reg(2'd3, 32'h8);
        read_reg(2'd3, d);
        sb_check(d);
        write_reg(2'd0, 32'd1);
        sb_push("abort_pwrup", 32'd1);
        tick();
        read_state(d);
        sb_check(d);
        tick();
        write_reg(2'd0, 32'd0);
        tick();
        sb_push("abort_pwrdn_len", 32'd6);
        n = 0;
        read_state(d);
        while (d == 32'd4 && n < 20) begin
            n++;
            tick();
            read_state(d);
        end
        sb_check(n);
        sb_push("abort_status", 32'h8);
        sb_push("abort_pwr", 32'd0);
        sb_push("abort_irq", 32'd0);
        read_reg(2'd3, d);
        sb_check(d);
        sb_check({31'd0, disp_pwr});
        sb_check({31'd0, irq});

        // DELAY=0: one-cycle PWR_UP/PWR_DN, en during PWR_DN restarts via OFF
        write_reg(2'd1, 32'd0);
        write_reg(2'd0, 32'd1);
        sb_push("d0_pwrup", 32'd1);
        sb_push("d0_on", 32'd2);
        tick();
        read_state(d);
        sb_check(d);
        tick();
        read_state(d);
        sb_check(d);
        write_reg(2'd0, 32'd0);
        sb_push("d0_pwrdn", 32'd4);
        tick();
        read_state(d);
        sb_check(d);
        sb_push("d0_off", 32'd0);
        sb_push("d0_off_pwr", 32'd0);
        write_reg(2'd0, 32'd1);
        read_state(d);
        sb_check(d);
        sb_check({31'd0, disp_pwr});
        sb_push("d0_repwrup", 32'd1);
        tick();
        read_state(d);
        sb_check(d);
        // Clear lands on the same edge that sets pend
        sb_push("pend_set_wins", 32'hA);
        write_reg(2'd3, 32'h8);
        read_reg(2'd3, d);
        sb_check(d);
        sb_push("pend_clear_alone", 32'h2);
        write_reg(2'd3, 32'h8);
        read_reg(2'd3, d);
        sb_check(d);

        // Asynchronous reset while in BLINK_OFF
        write_reg(2'd2, 32'd3);
        write_reg(2'd0, 32'h7);
        n = 0;
        read_state(d);
        while (d != 32'd3 && n < 20) begin
            tick();
            n++;
            read_state(d);
        end
        sb_push("reach_blink_off", 32'd3);
        sb_check(d);
        sb_push("blink_off_outs", 32'd2);
        sb_check({30'd0, disp_pwr, disp_en});
        reset_n = 1'b0;
        #1;
        sb_push("async_rst_outs", 32'd0);
        sb_check({29'd0, disp_pwr, disp_en, irq});
        for (int a = 0; a < 4; a++) begin
            sb_push($sformatf("async_rst_reg%0d", a), 32'd0);
            read_reg(a[1:0], d);
            sb_check(d);
        end
        tick();
        reset_n = 1'b1;
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
